// File: rtl/fb_pkg.sv
// Framebuffer geometry constants and the port arbiter state type.
package fb_pkg;

  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 128;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 2;

  typedef enum logic {
    RD_PRIO  = 1'b0,
    WR_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write buffer for the framebuffer arbiter; push is ignored when full,
// pop is ignored when empty.
module fb_wr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: reads win until a bounded burst starves a pending write.
// Optional build macro FB_ARB_BOUNDS_EN drops off-screen writes (x > 239) and flags err_oob.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_ready,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        mem_ce,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  input  logic [DATA_W-1:0]           mem_dout,
`ifdef FB_ARB_BOUNDS_EN
  output logic                        err_oob,
`endif
  output logic                        wr_pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BW = $clog2(MAX_RD_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_RD_BURST);

  arb_state_t               state, state_nxt;
  logic [BW-1:0]            burst_cnt, burst_nxt;
  logic                     rd_grant, wr_grant;
  logic                     fifo_full, fifo_empty, fifo_push;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  assign wr_ready = !fifo_full;

`ifdef FB_ARB_BOUNDS_EN
  logic wr_oob;
  assign wr_oob    = (wr_addr[7:0] >= 8'(FB_WIDTH));
  assign fifo_push = wr_valid && wr_ready && !wr_oob;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             err_oob <= 1'b0;
    else if (wr_valid && wr_ready && wr_oob) err_oob <= 1'b1;
  end
`else
  assign fifo_push = wr_valid && wr_ready;
`endif

  fb_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({wr_addr, wr_data}),
    .pop   (wr_grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_addr, head_data} = fifo_head;
  assign wr_pending = !fifo_empty;

  // WR_FORCE is entered exactly when the counter saturates, so it marks the cycle
  // whose single grant must be the starved write.
  always_comb begin
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    burst_nxt = burst_cnt;
    state_nxt = state;
    if (!reset) begin
      if (state == RD_PRIO && rd_req && (fifo_empty || burst_cnt < BURST_MAX))
        rd_grant = 1'b1;
      else if (!fifo_empty)
        wr_grant = 1'b1;
    end
    if (fifo_empty || wr_grant)
      burst_nxt = '0;
    else if (rd_grant && burst_cnt != BURST_MAX)
      burst_nxt = burst_cnt + BW'(1);
    case (state)
      RD_PRIO:  if (burst_nxt == BURST_MAX) state_nxt = WR_FORCE;
      WR_FORCE: state_nxt = RD_PRIO;
      default:  state_nxt = RD_PRIO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RD_PRIO;
      burst_cnt <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      rd_valid  <= rd_grant;
    end
  end

  assign rd_ready = rd_grant;
  assign rd_data  = mem_dout;
  assign mem_ce   = rd_grant || wr_grant;
  assign mem_we   = wr_grant;
  assign mem_addr = wr_grant ? head_addr : rd_addr;
  assign mem_din  = wr_grant ? head_data : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized and directed bench for fb_port_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_fb_port_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int MAXB  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready, rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          wr_pending;
  logic [2:0]    fifo_level;
`ifdef FB_ARB_BOUNDS_EN
  logic          err_oob;
  bit            err_exp;
`endif

  fb_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_RD_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout),
`ifdef FB_ARB_BOUNDS_EN
    .err_oob(err_oob),
`endif
    .wr_pending(wr_pending), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram     [0:32767];
  logic [DW-1:0] ref_ram [0:32767];

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout      <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           q[$];
  int            burst;
  bit            prev_rd;
  logic [DW-1:0] prev_data;
  int            n_vec, n_err, cyc;

  logic          s_rd_ready, s_rd_valid, s_mem_we, s_wr_ready;
  logic [DW-1:0] s_rd_data;
  logic [AW-1:0] s_mem_addr;
  logic [2:0]    s_fifo_level;

  logic [AW-1:0] we_log[$];
  int            we_cyc[$];

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return a[1:0] ^ a[9:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    burst   = 0;
    prev_rd = 1'b0;
`ifdef FB_ARB_BOUNDS_EN
    err_exp = 1'b0;
`endif
  endtask

  // One clock: drive inputs, check against the model at negedge, advance the model at posedge.
  task automatic cycle(input logic rq, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int lvl;
    bit exp_rd, exp_wr, acc;
    rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    cyc++;
    lvl    = q.size();
    exp_rd = rq && (lvl == 0 || burst < MAXB);
    exp_wr = !exp_rd && lvl != 0;
    acc    = wv && lvl < DEPTH;
`ifdef FB_ARB_BOUNDS_EN
    chk("err_oob", err_oob, err_exp);
    if (acc && wa[7:0] > 8'd239) begin
      err_exp = 1'b1;
      acc     = 1'b0;
    end
`endif
    chk("rd_ready", rd_ready, exp_rd);
    chk("wr_ready", wr_ready, lvl < DEPTH);
    chk("fifo_level", fifo_level, lvl);
    chk("wr_pending", wr_pending, lvl != 0);
    chk("mem_ce", mem_ce, exp_rd || exp_wr);
    chk("mem_we", mem_we, exp_wr);
    if (exp_rd) chk("mem_addr_rd", mem_addr, ra);
    if (exp_wr) begin
      chk("mem_addr_wr", mem_addr, q[0].addr);
      chk("mem_din", mem_din, q[0].data);
    end
    chk("rd_valid", rd_valid, prev_rd);
    if (prev_rd) chk("rd_data", rd_data, prev_data);
    s_rd_ready = rd_ready; s_rd_valid = rd_valid; s_rd_data = rd_data;
    s_mem_we = mem_we; s_mem_addr = mem_addr; s_wr_ready = wr_ready;
    s_fifo_level = fifo_level;
    if (mem_we) begin
      we_log.push_back(mem_addr);
      we_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (exp_wr) begin
      ref_ram[q[0].addr] = q[0].data;
      q.delete(0);
    end
    if (exp_rd) prev_data = ref_ram[ra];
    prev_rd = exp_rd;
    if (lvl == 0 || exp_wr)         burst = 0;
    else if (exp_rd && burst < MAXB) burst++;
    if (acc) q.push_back(wr_t'{addr: wa, data: wd});
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [7:0] x;
    logic [6:0] y;
    y = 7'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1, 2: x = 8'($urandom_range(0, 2));
      3, 4, 5: x = 8'($urandom_range(237, 239));
      default: x = 8'($urandom_range(240, 255));
    endcase
    return {y, x};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rr [3];
    int  n;
    bit  done, ok, prev_we;

    n_vec = 0; n_err = 0; cyc = 0;
    rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    reset = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      ram[i]     <= pattern(AW'(i));
      ref_ram[i]  = pattern(AW'(i));
    end
    model_reset();

    #2;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // idle writes
    we_log.delete(); we_cyc.delete();
    cycle(0, '0, 1, 15'h0000, 2'b01);
    cycle(0, '0, 1, 15'h0001, 2'b10);
    cycle(0, '0, 1, 15'h00EF, 2'b11);
    repeat (3) cycle(0, '0, 0, '0, '0);
    chk("idle_we_count", we_log.size(), 3);
    if (we_log.size() == 3) begin
      chk("idle_we0", we_log[0], 15'h0000);
      chk("idle_we1", we_log[1], 15'h0001);
      chk("idle_we2", we_log[2], 15'h00EF);
      chk("idle_we_consecutive", we_cyc[2] - we_cyc[0], 2);
    end
    chk("idle_level_zero", s_fifo_level, 0);

    // read latency
    ram[15'h1234] <= 2'b10;
    ref_ram[15'h1234] = 2'b10;
    cycle(1, 15'h1234, 0, '0, '0);
    chk("lat_rd_ready", s_rd_ready, 1);
    cycle(0, '0, 0, '0, '0);
    chk("lat_rd_valid", s_rd_valid, 1);
    chk("lat_rd_data", s_rd_data, 2'b10);

    // starvation, twice to show the burst counter restarts after the forced write
    for (int rep = 0; rep < 2; rep++) begin
      cycle(1, rand_addr(), 1, 15'h0105 + AW'(rep), 2'b01);
      n = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        cycle(1, rand_addr(), 0, '0, '0);
        if (s_mem_we) done = 1;
        else if (s_rd_ready) n++;
      end
      chk("starve_reads", n, MAXB);
      chk("starve_forced_write", done, 1);
      cycle(1, rand_addr(), 0, '0, '0);
      chk("starve_reads_resume", s_rd_ready, 1);
    end

    // full FIFO under continuous reads
    for (int i = 0; i < 4; i++) begin
      cycle(1, rand_addr(), 1, 15'h0200 + AW'(i), DW'(i));
      chk("full_accept", s_wr_ready, 1);
    end
    ok = 0; prev_we = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1, rand_addr(), 1, 15'h0204, 2'b11);
      if (k == 0) chk("full_wr_ready_5th", s_wr_ready, 0);
      if (s_wr_ready) begin
        chk("ready_after_pop", prev_we, 1);
        ok = 1;
        break;
      end
      prev_we = s_mem_we;
    end
    chk("full_5th_accepted", ok, 1);
    repeat (8) cycle(0, '0, 0, '0, '0);

    // asynchronous reset with three buffered writes
    rr[0] = 15'h2A10; rr[1] = 15'h2A11; rr[2] = 15'h2A12;
    for (int i = 0; i < 3; i++) cycle(1, rand_addr(), 1, rr[i], ~pattern(rr[i]));
    wr_valid = 0;
    @(negedge clk);
    chk("pre_reset_level", fifo_level, 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_ce", mem_ce, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_rd_ready", rd_ready, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_wr_pending", wr_pending, 0);
    chk("arst_fifo_level", fifo_level, 0);
    chk("arst_wr_ready", wr_ready, 1);
`ifdef FB_ARB_BOUNDS_EN
    chk("arst_err_oob", err_oob, 0);
`endif
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_we", mem_we, 0);
    end
    rd_req = 0;
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1, rr[i], 0, '0, '0);
    cycle(0, '0, 0, '0, '0);
    chk("discarded_not_written", s_rd_data, pattern(rr[2]));

    // off-screen write at x=240
    we_log.delete(); we_cyc.delete();
    cycle(0, '0, 1, 15'h00F0, 2'b11);
    repeat (3) cycle(0, '0, 0, '0, '0);
`ifdef FB_ARB_BOUNDS_EN
    chk("oob_no_we", we_log.size(), 0);
    chk("oob_err_set", err_oob, 1);
`else
    chk("oob_we_count", we_log.size(), 1);
    if (we_log.size() == 1) chk("oob_we_addr", we_log[0], 15'h00F0);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, rand_addr(), ($urandom % 2) == 1,
            rand_addr(), DW'($urandom));
    end
    repeat (12) cycle(0, '0, 0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
